// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter: the arcade CPU always has priority, and the hiscore engine uses a req/ack handshake.
// Once the hiscore side has been starved for STARVE_LIMIT cycles, the arbiter asks the core to pause.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no HPS access in flight; an HPS access is granted when the CPU is not using the port
// S_WAIT | RAM read data for the granted HPS access is on ram_dout
// S_ACK  | hs_ack pulse; returns to S_IDLE
module hiscore_ram_arbiter #(
   parameter int AW           = 12,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cpu_ce,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_pause,
   input  logic          hs_req,
   input  logic          hs_we,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_din,
   output logic [DW-1:0] hs_dout,
   output logic          hs_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

   state_t      state, state_nxt;
   logic        cpu_hit, hs_grant;
   logic        cpu_rd_d, hs_rd_q;
   logic [15:0] starve_cnt, starve_nxt;

   assign cpu_hit  = cpu_ce & cpu_cs;
   assign hs_grant = (state == S_IDLE) & hs_req & ~cpu_hit;
   assign hs_ack   = (state == S_ACK);
   assign busy     = (state != S_IDLE);

   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = 1'b0;
      if (cpu_hit) begin
         ram_we = cpu_we;
      end else if (hs_grant) begin
         ram_addr = hs_addr;
         ram_din  = hs_din;
         ram_we   = hs_we;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (hs_grant) state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_ACK;
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counts only denied cycles in IDLE, so it holds while a granted access is in flight.
   always_comb begin
      starve_nxt = starve_cnt;
      if (!hs_req || hs_grant)
         starve_nxt = '0;
      else if (state == S_IDLE && starve_cnt != LIMIT)
         starve_nxt = starve_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cpu_rd_d   <= 1'b0;
         hs_rd_q    <= 1'b0;
         cpu_dout   <= '0;
         hs_dout    <= '0;
         starve_cnt <= '0;
         cpu_pause  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cpu_rd_d   <= cpu_hit & ~cpu_we;
         starve_cnt <= starve_nxt;
         if (cpu_rd_d)
            cpu_dout <= ram_dout;
         if (hs_grant)
            hs_rd_q <= ~hs_we;
         if (state == S_WAIT && hs_rd_q)
            hs_dout <= ram_dout;
         if (state == S_ACK)
            cpu_pause <= 1'b0;
         else if (starve_nxt == LIMIT)
            cpu_pause <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a 1-cycle synchronous RAM model behind the port.
module tb_hiscore_ram_arbiter;

   localparam int AW = 12;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cpu_ce = 1'b0, cpu_cs = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;
   logic [DW-1:0] cpu_dout;
   logic          cpu_pause;
   logic          hs_req = 1'b0, hs_we = 1'b0;
   logic [AW-1:0] hs_addr = '0;
   logic [DW-1:0] hs_din = '0;
   logic [DW-1:0] hs_dout;
   logic          hs_ack;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic          busy;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] mem [4096];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   hiscore_ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_pause(cpu_pause),
      .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din),
      .hs_dout(hs_dout), .hs_ack(hs_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy)
   );

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL reset_cpu_dout got %h exp 00", cpu_dout); end
      tests++; if (hs_dout !== 8'h00) begin fails++; $display("FAIL reset_hs_dout got %h exp 00", hs_dout); end
      tests++; if ({hs_ack, busy, cpu_pause, ram_we} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {hs_ack, busy, cpu_pause, ram_we}); end
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_cpu_rw();
      cpu_cs = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'h5A;
      #1;
      tests++; if (ram_we !== 1'b1 || ram_addr !== 12'h123 || ram_din !== 8'h5A) begin fails++; $display("FAIL cpu_wr_port got we=%b addr=%h din=%h exp 1/123/5a", ram_we, ram_addr, ram_din); end
      cyc();
      cpu_ce = 1'b0;
      #1;
      tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL cpu_wr_one_cycle got %b exp 0", ram_we); end
      cyc();
      cpu_ce = 1'b1; cpu_we = 1'b0;
      #1;
      tests++; if (ram_we !== 1'b0 || ram_addr !== 12'h123) begin fails++; $display("FAIL cpu_rd_port got we=%b addr=%h exp 0/123", ram_we, ram_addr); end
      cyc();
      cpu_ce = 1'b0;
      tests++; if (cpu_dout !== 8'h00) begin fails++; $display("FAIL cpu_rd_early got %h exp 00", cpu_dout); end
      cyc();
      tests++; if (cpu_dout !== 8'h5A) begin fails++; $display("FAIL cpu_rd_data got %h exp 5a", cpu_dout); end
      // preload 0x0FF with C3 for the hiscore read tests
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0FF; cpu_din = 8'hC3;
      cyc();
      cpu_ce = 1'b0; cpu_we = 1'b0;
      cyc();
   endtask

   task automatic test_hs_read();
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 12'h0FF;
      #1;
      tests++; if (ram_addr !== 12'h0FF || ram_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hs_rd_grant got addr=%h we=%b busy=%b exp 0ff/0/0", ram_addr, ram_we, busy); end
      cyc();
      hs_req = 1'b0;
      tests++; if (busy !== 1'b1 || hs_ack !== 1'b0) begin fails++; $display("FAIL hs_rd_c1 got busy=%b ack=%b exp 1/0", busy, hs_ack); end
      cyc();
      tests++; if (busy !== 1'b1 || hs_ack !== 1'b1) begin fails++; $display("FAIL hs_rd_c2 got busy=%b ack=%b exp 1/1", busy, hs_ack); end
      tests++; if (hs_dout !== 8'hC3) begin fails++; $display("FAIL hs_rd_data got %h exp c3", hs_dout); end
      cyc();
      tests++; if (busy !== 1'b0 || hs_ack !== 1'b0) begin fails++; $display("FAIL hs_rd_c3 got busy=%b ack=%b exp 0/0", busy, hs_ack); end
   endtask

   task automatic test_reset_mid_wait();
      int acks;
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 12'h123;
      cyc();
      hs_req = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_wait_entered got busy=%b exp 1", busy); end
      #2 reset_n = 1'b0;
      #1;
      tests++; if (cpu_dout !== 8'h00 || hs_dout !== 8'h00) begin fails++; $display("FAIL rst_wait_data got cpu=%h hs=%h exp 00/00", cpu_dout, hs_dout); end
      tests++; if ({hs_ack, busy, cpu_pause, ram_we} !== 4'b0) begin fails++; $display("FAIL rst_wait_flags got %b exp 0000", {hs_ack, busy, cpu_pause, ram_we}); end
      cyc();
      reset_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         if (hs_ack === 1'b1 || busy === 1'b1) acks++;
         cyc();
      end
      tests++; if (acks !== 0) begin fails++; $display("FAIL rst_wait_no_ack got %0d exp 0", acks); end
   endtask

   task automatic test_collision();
      cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
      hs_req = 1'b1; hs_we = 1'b1; hs_addr = 12'h200; hs_din = 8'h77;
      #1;
      tests++; if (ram_addr !== 12'h123 || ram_we !== 1'b0) begin fails++; $display("FAIL coll_cpu_wins got addr=%h we=%b exp 123/0", ram_addr, ram_we); end
      cyc();
      cpu_ce = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coll_stay_idle got busy=%b exp 0", busy); end
      #1;
      tests++; if (ram_addr !== 12'h200 || ram_we !== 1'b1 || ram_din !== 8'h77) begin fails++; $display("FAIL coll_hs_grant got addr=%h we=%b din=%h exp 200/1/77", ram_addr, ram_we, ram_din); end
      cyc();
      hs_req = 1'b0; hs_we = 1'b0;
      tests++; if (cpu_dout !== 8'h5A) begin fails++; $display("FAIL coll_cpu_data got %h exp 5a", cpu_dout); end
      cyc();
      tests++; if (hs_ack !== 1'b1) begin fails++; $display("FAIL coll_ack got %b exp 1", hs_ack); end
      cyc();
      tests++; if (mem[12'h200] !== 8'h77) begin fails++; $display("FAIL coll_ram got %h exp 77", mem[12'h200]); end
   endtask

   task automatic test_starvation();
      cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 12'h0FF;
      for (int i = 0; i < 4; i++) begin
         tests++; if (cpu_pause !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL starve_denied%0d got pause=%b busy=%b exp 0/0", i, cpu_pause, busy); end
         cyc();
      end
      tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL starve_pause_rise got %b exp 1", cpu_pause); end
      #1;
      tests++; if (ram_addr !== 12'h010) begin fails++; $display("FAIL starve_cpu_prio got addr=%h exp 010", ram_addr); end
      cyc();
      tests++; if (cpu_pause !== 1'b1) begin fails++; $display("FAIL starve_pause_hold got %b exp 1", cpu_pause); end
      cpu_ce = 1'b0;
      #1;
      tests++; if (ram_addr !== 12'h0FF || busy !== 1'b0) begin fails++; $display("FAIL starve_grant got addr=%h busy=%b exp 0ff/0", ram_addr, busy); end
      cyc();
      hs_req = 1'b0;
      tests++; if (busy !== 1'b1 || cpu_pause !== 1'b1) begin fails++; $display("FAIL starve_wait got busy=%b pause=%b exp 1/1", busy, cpu_pause); end
      cyc();
      tests++; if (hs_ack !== 1'b1 || cpu_pause !== 1'b1 || hs_dout !== 8'hC3) begin fails++; $display("FAIL starve_ack got ack=%b pause=%b dout=%h exp 1/1/c3", hs_ack, cpu_pause, hs_dout); end
      cyc();
      tests++; if (cpu_pause !== 1'b0 || hs_ack !== 1'b0) begin fails++; $display("FAIL starve_pause_clear got pause=%b ack=%b exp 0/0", cpu_pause, hs_ack); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3];
      logic [DW-1:0] datas [3];
      int acks;
      addrs[0] = 12'h300; addrs[1] = 12'h301; addrs[2] = 12'hABC;
      datas[0] = 8'h11;   datas[1] = 8'h22;   datas[2] = 8'h33;
      acks = 0;
      hs_req = 1'b1; hs_we = 1'b1;
      for (int t = 0; t < 3; t++) begin
         hs_addr = addrs[t]; hs_din = datas[t];
         #1;
         tests++; if (busy !== 1'b0 || ram_we !== 1'b1 || ram_addr !== addrs[t]) begin fails++; $display("FAIL b2b_grant%0d got busy=%b we=%b addr=%h exp 0/1/%h", t, busy, ram_we, ram_addr, addrs[t]); end
         cyc();
         if (hs_ack === 1'b1) acks++;
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_wait%0d got busy=%b exp 1", t, busy); end
         cyc();
         if (hs_ack === 1'b1) acks++;
         cyc();
      end
      hs_req = 1'b0; hs_we = 1'b0;
      tests++; if (acks !== 3) begin fails++; $display("FAIL b2b_acks got %0d exp 3", acks); end
      for (int t = 0; t < 3; t++) begin
         tests++; if (mem[addrs[t]] !== datas[t]) begin fails++; $display("FAIL b2b_ram%0d got %h exp %h", t, mem[addrs[t]], datas[t]); end
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_cpu_rw();
      test_hs_read();
      test_reset_mid_wait();
      test_collision();
      test_starvation();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
